// File: rtl/exe_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : exe_unit_arbiter                                                |
// | Brief    : Round-robin sharing of one fixed-latency exe unit by two ports  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module exe_unit_arbiter #(
  parameter int M   = 4,
  parameter int N   = 2,
  parameter int LAT = 1
) (
  input  logic         i_clk,
  input  logic         i_rsn,
  input  logic         i_req0_valid,
  output logic         o_req0_ready,
  input  logic [N-1:0] i_req0_oper,
  input  logic [M-1:0] i_req0_argA,
  input  logic [M-1:0] i_req0_argB,
  input  logic         i_req1_valid,
  output logic         o_req1_ready,
  input  logic [N-1:0] i_req1_oper,
  input  logic [M-1:0] i_req1_argA,
  input  logic [M-1:0] i_req1_argB,
  output logic         o_rsp0_valid,
  output logic         o_rsp1_valid,
  output logic [M-1:0] o_rsp_result,
  output logic [1:0]   o_rsp_status,
  output logic [N-1:0] o_exe_oper,
  output logic [M-1:0] o_exe_argA,
  output logic [M-1:0] o_exe_argB,
  input  logic [M-1:0] i_exe_result,
  input  logic [1:0]   i_exe_status
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_ptr;    // port preferred on contention; 0 after reset
  logic          r_owner;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic          w_cnt_done;

  // Ready is masked by reset so toggling inputs during reset never show through.
  assign w_grant0 = i_rsn && (r_state == S_IDLE) && i_req0_valid &&
                    (!i_req1_valid || !r_ptr);
  assign w_grant1 = i_rsn && (r_state == S_IDLE) && i_req1_valid &&
                    (!i_req0_valid || r_ptr);
  assign w_accept   = w_grant0 || w_grant1;
  assign w_cnt_done = (r_cnt == CW'(LAT - 1));

  assign o_req0_ready = w_grant0;
  assign o_req1_ready = w_grant1;
  assign o_rsp0_valid = (r_state == S_RESP) && !r_owner;
  assign o_rsp1_valid = (r_state == S_RESP) && r_owner;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_WAIT;
      S_WAIT:  if (w_cnt_done) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rsn) begin
    if (!i_rsn) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_ptr        <= 1'b0;
      r_owner      <= 1'b0;
      o_exe_oper   <= '0;
      o_exe_argA   <= '0;
      o_exe_argB   <= '0;
      o_rsp_result <= '0;
      o_rsp_status <= '0;
    end else begin
      r_state <= w_next;

      if (w_accept) begin
        r_owner    <= w_grant1;
        r_ptr      <= w_grant0;
        o_exe_oper <= w_grant1 ? i_req1_oper : i_req0_oper;
        o_exe_argA <= w_grant1 ? i_req1_argA : i_req0_argA;
        o_exe_argB <= w_grant1 ? i_req1_argB : i_req0_argB;
      end

      // The exe output is sampled exactly LAT edges after the operands changed.
      if (r_state == S_WAIT) begin
        if (w_cnt_done) begin
          r_cnt        <= '0;
          o_rsp_result <= i_exe_result;
          o_rsp_status <= i_exe_status;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_unit_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_exe_unit_arbiter                                             |
// | Brief    : Scoreboard bench for exe_unit_arbiter, LAT=1 and LAT=3 lanes    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_exe_unit_arbiter;

  localparam int M  = 4;
  localparam int N  = 2;
  localparam int CB = N + 2 * M;

  typedef struct {
    int         port;
    logic [M-1:0] res;
    logic [1:0] st;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [CB-1:0] rnd_cmd();
    return CB'($urandom);
  endfunction

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_lane
    localparam int L    = (gi == 0) ? 1 : 3;
    localparam int PIDX = (L > 1) ? L - 2 : 0;

    logic         rst_n = 1'b0;
    logic         v0 = 1'b0, v1 = 1'b0;
    logic [N-1:0] op0 = '0, op1 = '0;
    logic [M-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         rdy0, rdy1, rsp0, rsp1;
    logic [M-1:0] rsp_res;
    logic [1:0]   rsp_st;
    logic [N-1:0] exe_op;
    logic [M-1:0] exe_a, exe_b;
    logic [M-1:0] exe_res;
    logic [1:0]   exe_st;
    logic         r_done = 1'b0;

    // Stub exe: operands must be stable for L edges before the output is right.
    logic [M+1:0] w_stub_now;
    logic [M+1:0] r_pipe [L];
    assign w_stub_now = {exe_a[M-1], exe_b[M-1], exe_a ^ exe_b};
    always @(posedge clk) begin
      r_pipe[0] <= w_stub_now;
      for (int i = 1; i < L; i++) r_pipe[i] <= r_pipe[i-1];
    end
    assign exe_res = (L == 1) ? w_stub_now[M-1:0]   : r_pipe[PIDX][M-1:0];
    assign exe_st  = (L == 1) ? w_stub_now[M+1:M]   : r_pipe[PIDX][M+1:M];

    exe_unit_arbiter #(.M(M), .N(N), .LAT(L)) u_dut (
      .i_clk        (clk),
      .i_rsn        (rst_n),
      .i_req0_valid (v0),
      .o_req0_ready (rdy0),
      .i_req0_oper  (op0),
      .i_req0_argA  (a0),
      .i_req0_argB  (b0),
      .i_req1_valid (v1),
      .o_req1_ready (rdy1),
      .i_req1_oper  (op1),
      .i_req1_argA  (a1),
      .i_req1_argB  (b1),
      .o_rsp0_valid (rsp0),
      .o_rsp1_valid (rsp1),
      .o_rsp_result (rsp_res),
      .o_rsp_status (rsp_st),
      .o_exe_oper   (exe_op),
      .o_exe_argA   (exe_a),
      .o_exe_argB   (exe_b),
      .i_exe_result (exe_res),
      .i_exe_status (exe_st)
    );

    // Reference model state: arbiter free time, last winner, held exe operands.
    exp_t          q[$];
    int            last    = 1;
    int            free_at = 0;
    logic [CB-1:0] exe_m   = '0;
    logic [CB-1:0] cmd [2];
    bit            have [2];
    bit            rst_want = 1'b0;
    logic [M+1:0]  held = '0;

    task automatic step();
      int w;
      logic [M-1:0] ta, tb_;
      @(posedge clk);
      #1;
      rst_n = rst_want;
      if (!rst_want) begin
        v0 = 1'($urandom); v1 = 1'($urandom);
        {op0, a0, b0} = rnd_cmd();
        {op1, a1, b1} = rnd_cmd();
      end else begin
        v0 = have[0]; v1 = have[1];
        {op0, a0, b0} = cmd[0];
        {op1, a1, b1} = cmd[1];
      end
      @(negedge clk);
      if (!rst_n) begin
        chk($sformatf("L%0d reset ready0", L), rdy0, 0);
        chk($sformatf("L%0d reset ready1", L), rdy1, 0);
        chk($sformatf("L%0d reset exe", L), {exe_op, exe_a, exe_b}, 0);
        last = 1; free_at = cyc + 1; exe_m = '0;
      end else begin
        chk($sformatf("L%0d exe hold", L), {exe_op, exe_a, exe_b}, exe_m);
        w = -1;
        if (cyc >= free_at && (v0 || v1))
          w = (v0 && v1) ? ((last == 0) ? 1 : 0) : (v0 ? 0 : 1);
        chk($sformatf("L%0d ready0", L), rdy0, (w == 0));
        chk($sformatf("L%0d ready1", L), rdy1, (w == 1));
        if (w >= 0) begin
          exp_t e;
          ta  = cmd[w][2*M-1:M];
          tb_ = cmd[w][M-1:0];
          e.port = w;
          e.res  = ta ^ tb_;
          e.st   = {ta[M-1], tb_[M-1]};
          e.due  = cyc + L + 1;
          q.push_back(e);
          exe_m   = cmd[w];
          last    = w;
          free_at = cyc + L + 2;
          have[w] = 1'b0;
        end
      end
    endtask

    task automatic serve();
      int k = 0;
      while ((have[0] || have[1]) && k < 60) begin
        step();
        k++;
      end
      chk($sformatf("L%0d grant timeout", L), have[0] | have[1], 0);
    endtask

    task automatic idle(input int n);
      repeat (n) step();
    endtask

    initial begin : p_drive
      have[0] = 0; have[1] = 0;
      cmd[0] = '0; cmd[1] = '0;
      rst_want = 0;
      idle(4);
      rst_want = 1;
      idle(1);

      cmd[0] = {2'b11, 4'b1111, 4'b0000};
      have[0] = 1;
      serve();
      idle(L + 3);

      rst_want = 0;
      idle(2);
      rst_want = 1;
      cmd[0] = rnd_cmd(); cmd[1] = rnd_cmd();
      have[0] = 1; have[1] = 1;
      for (int i = 0; i < 6 * (L + 2); i++) begin
        step();
        if (!have[0]) begin cmd[0] = rnd_cmd(); have[0] = 1; end
        if (!have[1]) begin cmd[1] = rnd_cmd(); have[1] = 1; end
      end
      have[0] = 0;
      serve();
      idle(L + 3);

      for (int i = 0; i < 5 * (L + 2); i++) begin
        if (!have[1]) begin cmd[1] = rnd_cmd(); have[1] = 1; end
        step();
      end
      serve();
      idle(L + 3);

      cmd[0] = rnd_cmd();
      have[0] = 1;
      serve();
      rst_want = 0;
      idle(3);
      rst_want = 1;
      idle(1);
      cmd[0] = rnd_cmd();
      have[0] = 1;
      serve();
      idle(L + 3);

      for (int i = 0; i < 200; i++) begin
        for (int p = 0; p < 2; p++)
          if (!have[p] && ($urandom_range(2) == 0)) begin
            cmd[p] = rnd_cmd();
            have[p] = 1;
          end
        step();
      end
      serve();
      idle(L + 4);
      r_done = 1'b1;
    end

    initial begin : p_monitor
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          chk($sformatf("L%0d reset rsp", L), {rsp0, rsp1, rsp_st, rsp_res}, 0);
          q.delete();
          held = '0;
        end else if (rsp0 || rsp1) begin
          chk($sformatf("L%0d rsp both", L), rsp0 & rsp1, 0);
          if (q.size() == 0) begin
            chk($sformatf("L%0d rsp unexpected", L), 1, 0);
          end else begin
            e = q.pop_front();
            chk($sformatf("L%0d rsp port", L), rsp1 ? 1 : 0, e.port);
            chk($sformatf("L%0d rsp cycle", L), cyc, e.due);
            chk($sformatf("L%0d rsp result", L), rsp_res, e.res);
            chk($sformatf("L%0d rsp status", L), rsp_st, e.st);
          end
          held = {rsp_st, rsp_res};
        end else begin
          chk($sformatf("L%0d rsp hold", L), {rsp_st, rsp_res}, held);
          if (q.size() > 0 && q[0].due <= cyc) begin
            chk($sformatf("L%0d rsp missing", L), 0, 1);
            void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin : p_end
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk);
      if (g_lane[0].r_done && g_lane[1].r_done) break;
    end
    chk("run timeout", g_lane[0].r_done & g_lane[1].r_done, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
